sram_vec_reader: RTL
====================

Name: sram_vec_reader

Overview:
Test-runner-side initiator on the SRAM arbiter's tr_* port. It reads a block of 16-bit test-vector words that the SOPC side has already written to SRAM. The words are buffered in a small FIFO and streamed out on a valid/ready interface to the vector-application logic. One instance sits between sram_arb (tr_* port) and the chip-tester vector engine.

Parameters:
ADDR_WIDTH, 20, SRAM word-address width
DATA_WIDTH, 16, SRAM data width
FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2
CNT_WIDTH, 21, width of word_count (ADDR_WIDTH+1 so a full SRAM fits)

Ports:
clock  in  1  sole clock, same domain as sram_arb
reset  in  1  synchronous, active-high
start  in  1  single-cycle pulse; latches base_addr/word_count when idle
base_addr  in  ADDR_WIDTH  first word address
word_count  in  CNT_WIDTH  number of words to read
busy  out  1  high from accepted start until done
done  out  1  single-cycle pulse after the last word leaves the FIFO
tr_address  out  ADDR_WIDTH  read address to arbiter
tr_byteenable  out  2  constant 2'b11
tr_read  out  1  read request
tr_write  out  1  constant 0
tr_writedata  out  DATA_WIDTH  constant 0
tr_readdata  in  DATA_WIDTH  read data
tr_waitrequest  in  1  arbiter stall
out_data  out  DATA_WIDTH  stream data (FIFO head)
out_valid  out  1  stream valid
out_ready  in  1  stream ready

Behaviour:
- Reset values: busy=0, done=0, tr_read=0, tr_address=0, out_valid=0, FIFO empty, FSM=IDLE.
- Bus rule: tr_read and tr_address stay stable while tr_waitrequest=1. A read completes in the cycle where tr_read=1 and tr_waitrequest=0. tr_readdata is sampled in that same cycle (zero read latency) and pushed into the FIFO.
- FSM states:
  - IDLE: start=1 latches base_addr into addr_q and word_count into remaining. If word_count=0, go to FIN; else go to READ. busy=1 from the next cycle.
  - READ: tr_read=1 only when the FIFO has at least one free slot, counting the pending completion. On each completion: addr_q+1 (wraps mod 2^ADDR_WIDTH), remaining-1. When remaining reaches 0 on a completion, go to DRAIN.
  - DRAIN: tr_read=0. Wait until the FIFO is empty, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- start while busy: ignored. No restart and no parameter change.
- Back-to-back reads: one completion per cycle when waitrequest=0 and out_ready=1 → sustained throughput of 1 word/clock.
- FIFO:
  - A simultaneous push and pop on a full FIFO is legal; the count is unchanged.
  - A push is never issued when count=FIFO_DEPTH with no pop in the same cycle. The read gate uses the registered count, so a full FIFO deasserts tr_read before the request.
  - out_valid = !empty. out_data is stable while out_valid=1 and out_ready=0.
- Latency: a start accepted in cycle 0 gives tr_read=1 in cycle 1. The first out_valid comes one cycle after the first completion.
- reset mid-operation: everything returns to the reset values in the next cycle. The FIFO is flushed and no done pulse is produced.

Optional Feature:
SRAM_VEC_READER_CHECKSUM_EN:
- With the macro defined: extra output checksum [DATA_WIDTH-1:0], a running modulo-2^DATA_WIDTH sum of every word popped on the stream. It is cleared when start is accepted and is valid and held from the done pulse until the next accepted start. It resets to 0.
- Without the macro: the port and its logic are absent.

Decomposition:
- Shared package sram_vec_pkg:
  - FSM state enum: IDLE, READ, DRAIN, FIN.
  - Default width constants: ADDR_WIDTH, DATA_WIDTH.
  - BE_ALL=2'b11.
- One sub-module, sync_fifo: parameterised by width and depth, with push/pop/full/empty/count outputs, synchronous active-high reset. The reader FSM and address/counter logic stay in the top module.

Test Plan:
- Basic read: SRAM model holds mem[0x100+i]=0xA000+i; start with base=0x100, count=4, waitrequest=0, out_ready=1 → stream 0xA000..0xA003 in order, reads on 4 consecutive cycles, exactly one done pulse, then busy=0.
- Zero count: start with count=0 → no tr_read, done pulse 2 cycles after start, out_valid never asserted.
- Backpressure: count=20, out_ready=0 → tr_read stops after exactly 8 completions; raise out_ready → all 20 words arrive in order with none lost or duplicated.
- Stalls and wrap: random tr_waitrequest with base=0xFFFFE, count=4 → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001; address held stable during every stall.
- Reset and ignored start: reset asserted after 3 of 10 words → next cycle busy=0, out_valid=0, tr_read=0, no done pulse. Separately, a start pulsed while busy leaves the word sequence unchanged.
- Checksum (macro defined): words 0xFFFF, 0x0002, 0x0010 → checksum=0x0011 at done.

Source files
------------

// File: rtl/sram_vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_vec_pkg
// Brief    : Shared types and constants for the SRAM test-vector reader.
// Revision : 1.0 - initial release
// ============================================================================
package sram_vec_pkg;

    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_DATA_WIDTH = 16;

    localparam logic [1:0] BE_ALL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage : sram_vec_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO; push on full is accepted only with a same-cycle pop.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 8,
    localparam int c_ptr_w  = $clog2(DEPTH),
    localparam int c_cnt_w  = c_ptr_w + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [c_cnt_w-1:0] o_count
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/sram_vec_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_vec_reader
// Brief    : Reads a block of SRAM words via the arbiter tr_* port and streams
//            them out through a FIFO. Define SRAM_VEC_READER_CHECKSUM_EN to add
//            a running checksum output of the streamed words.
// Revision : 1.0 - initial release
// ============================================================================
module sram_vec_reader
    import sram_vec_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] tr_address,
    output logic [1:0]            tr_byteenable,
    output logic                  tr_read,
    output logic                  tr_write,
    output logic [DATA_WIDTH-1:0] tr_writedata,
    input  logic [DATA_WIDTH-1:0] tr_readdata,
    input  logic                  tr_waitrequest,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef SRAM_VEC_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int c_fifo_cnt_w = $clog2(FIFO_DEPTH) + 1;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [CNT_WIDTH-1:0]    r_remaining;
    logic                    r_done;
    logic                    w_start_acc;
    logic                    w_complete;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [c_fifo_cnt_w-1:0] w_fifo_count;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_complete  = tr_read && !tr_waitrequest;
    assign w_pop       = out_valid && out_ready;

    // The gate sees only the registered fill level, so it never depends on out_ready.
    assign tr_read       = (r_state == READ) && !w_full;
    assign tr_address    = r_addr;
    assign tr_byteenable = BE_ALL;
    assign tr_write      = 1'b0;
    assign tr_writedata  = '0;
    assign out_valid     = !w_empty;
    assign busy          = (r_state == READ) || (r_state == DRAIN);
    assign done          = r_done;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_complete),
        .i_data  (tr_readdata),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (word_count == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (w_complete && (r_remaining == CNT_WIDTH'(1))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifo_count == '0) begin
                    w_state_nxt = FIN;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            if (w_start_acc) begin
                r_addr      <= base_addr;
                r_remaining <= word_count;
            end else if (w_complete) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

`ifdef SRAM_VEC_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + out_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule : sram_vec_reader
`default_nettype wire
